// File: rtl/nlp_assoc_if.sv
// Fetch-side prediction signals and commit-side update signals of the
// next-line predictor, bundled so the fetch unit and predictor share one port.
interface nlp_assoc_if #(
  parameter int FETCH_WIDTH = 4
);
  localparam int SLOT_W = $clog2(FETCH_WIDTH);

  logic              flush;
  logic [31:0]       pc;
  logic              pred_valid;
  logic              hit;
  logic              taken;
  logic [31:0]       next_fetch_pc;
  logic [SLOT_W-1:0] cut_pos;
  logic              update_valid;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic [1:0]        update_type;

  // Fetch/commit side: drives lookups and updates, consumes predictions.
  modport master (
    output flush, pc, update_valid, update_pc, update_taken, update_target, update_type,
    input  pred_valid, hit, taken, next_fetch_pc, cut_pos
  );

  // Predictor side.
  modport slave (
    input  flush, pc, update_valid, update_pc, update_taken, update_target, update_type,
    output pred_valid, hit, taken, next_fetch_pc, cut_pos
  );
endinterface

// File: rtl/nlp_assoc.sv
// Fully-associative micro-BTB next-line predictor with 2-bit direction
// counters, round-robin replacement and a commit-updated return stack.
// Prediction is combinational; updates land on the clock edge.
module nlp_assoc #(
  parameter int ENTRIES     = 16,
  parameter int FETCH_WIDTH = 4,
  parameter int RAS_DEPTH   = 8
) (
  input logic       clk,
  input logic       rst,
  nlp_assoc_if.slave bus
);
  localparam int SLOT_W = $clog2(FETCH_WIDTH);
  localparam int OFF    = SLOT_W + 2;
  localparam int TAG_W  = 32 - OFF;
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int RAS_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RAS_DEPTH + 1);

  localparam logic [31:0]      GROUP_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [CNT_W-1:0] RAS_FULL    = CNT_W'(RAS_DEPTH);
  localparam logic [1:0]       TYPE_CALL   = 2'd2;
  localparam logic [1:0]       TYPE_RET    = 2'd3;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [SLOT_W-1:0]  slot   [ENTRIES];
  logic [1:0]         btype  [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr;

  logic [31:0]        ras_mem [RAS_DEPTH];
  logic [RAS_W-1:0]   ras_top;
  logic [CNT_W-1:0]   ras_cnt;

  logic               look_hit;
  logic [IDX_W-1:0]   look_idx;
  logic               upd_hit;
  logic [IDX_W-1:0]   upd_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   victim;
  logic               pred_taken;
  logic [31:0]        seq_pc;
  logic [RAS_W-1:0]   ras_push_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic [SLOT_W-1:0]  upd_slot;

  assign upd_tag  = bus.update_pc[31:OFF];
  assign upd_slot = bus.update_pc[OFF-1:2];

  // Fetch-group tag match; allocation only on a miss keeps tags unique.
  always_comb begin
    look_hit = 1'b0;
    look_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == bus.pc[31:OFF]) begin
        look_hit = 1'b1;
        look_idx = IDX_W'(i);
      end
    end
  end

  // Update-side tag match and lowest-index free entry search.
  always_comb begin
    upd_hit    = 1'b0;
    upd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == upd_tag) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign victim       = free_found ? free_idx : rr_ptr;
  assign seq_pc       = {bus.pc[31:OFF], {OFF{1'b0}}} + GROUP_BYTES;
  assign pred_taken   = look_hit && ctr[look_idx][1];
  assign ras_push_idx = ras_top + RAS_W'(1);

  assign bus.pred_valid = !bus.flush;
  assign bus.hit        = look_hit;
  assign bus.taken      = pred_taken;
  assign bus.cut_pos    = pred_taken ? slot[look_idx] + SLOT_W'(1) : '0;

  // Next fetch PC: returns prefer the RAS top while it holds anything.
  always_comb begin
    bus.next_fetch_pc = seq_pc;
    if (pred_taken) begin
      if (btype[look_idx] == TYPE_RET && ras_cnt != '0) begin
        bus.next_fetch_pc = ras_mem[ras_top];
      end else begin
        bus.next_fetch_pc = target[look_idx];
      end
    end
  end

  // uBTB training and allocation; flush deliberately has no effect here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag[i]    <= '0;
        target[i] <= '0;
        slot[i]   <= '0;
        btype[i]  <= '0;
        ctr[i]    <= '0;
      end
    end else if (bus.update_valid) begin
      if (upd_hit) begin
        if (bus.update_taken) begin
          if (ctr[upd_idx] != 2'b11) ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
          target[upd_idx] <= bus.update_target;
          slot[upd_idx]   <= upd_slot;
          btype[upd_idx]  <= bus.update_type;
        end else if (ctr[upd_idx] != 2'b00) begin
          ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
        end
      end else if (bus.update_taken) begin
        valid[victim]  <= 1'b1;
        tag[victim]    <= upd_tag;
        target[victim] <= bus.update_target;
        slot[victim]   <= upd_slot;
        btype[victim]  <= bus.update_type;
        ctr[victim]    <= 2'b10;
        if (!free_found) rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  // Return stack: a full push wraps onto the oldest slot; flush wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_top <= '0;
      ras_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (bus.flush) begin
      ras_top <= '0;
      ras_cnt <= '0;
    end else if (bus.update_valid && bus.update_taken) begin
      if (bus.update_type == TYPE_CALL) begin
        ras_top               <= ras_push_idx;
        ras_mem[ras_push_idx] <= bus.update_pc + 32'd4;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (bus.update_type == TYPE_RET && ras_cnt != '0) begin
        ras_top <= ras_top - RAS_W'(1);
        ras_cnt <= ras_cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_nlp_assoc.sv
// Self-checking bench for nlp_assoc: directed vector table, replacement and
// return-stack sequences, asynchronous reset, and a randomized run against
// a behavioural model of the predictor.
module tb_nlp_assoc;
  localparam int ENTRIES   = 16;
  localparam int FW        = 4;
  localparam int RAS_DEPTH = 8;
  localparam int OFF       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nlp_assoc_if #(.FETCH_WIDTH(FW)) bus ();

  nlp_assoc #(.ENTRIES(ENTRIES), .FETCH_WIDTH(FW), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a table of entries plus a queue for the return stack.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int unsigned m_slot  [ENTRIES];
  int unsigned m_type  [ENTRIES];
  int unsigned m_ctr   [ENTRIES];
  int          m_rr;
  int unsigned m_ras[$];

  typedef struct {
    bit          fl;
    bit          uv;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utgt;
    logic [1:0]  uty;
    logic [31:0] lpc;
    bit          eh;
    bit          et;
    logic [31:0] en;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 0;
    end
    m_rr = 0;
    m_ras.delete();
  endfunction

  function automatic int model_find(input int unsigned a);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == (a >> OFF)) return i;
    return -1;
  endfunction

  task automatic model_predict(input int unsigned a, output bit h, output bit t,
                               output int unsigned nxt, output int unsigned cut);
    int k;
    k   = model_find(a);
    h   = (k >= 0);
    t   = h && (m_ctr[k] >= 2);
    nxt = ((a >> OFF) << OFF) + FW * 4;
    cut = 0;
    if (t) begin
      cut = (m_slot[k] + 1) % FW;
      if (m_type[k] == 3 && m_ras.size() > 0) nxt = m_ras[m_ras.size() - 1];
      else nxt = m_tgt[k];
    end
  endtask

  task automatic model_update(input bit fl, input bit uv, input int unsigned upc, input bit ut,
                              input int unsigned utgt, input int unsigned uty);
    int k;
    int v;
    if (uv) begin
      k = model_find(upc);
      if (k >= 0) begin
        if (ut) begin
          if (m_ctr[k] < 3) m_ctr[k]++;
          m_tgt[k]  = utgt;
          m_slot[k] = (upc >> 2) % FW;
          m_type[k] = uty;
        end else if (m_ctr[k] > 0) begin
          m_ctr[k]--;
        end
      end else if (ut) begin
        v = -1;
        for (int i = 0; i < ENTRIES; i++)
          if (!m_valid[i] && v < 0) v = i;
        if (v < 0) begin
          v    = m_rr;
          m_rr = (m_rr + 1) % ENTRIES;
        end
        m_valid[v] = 1'b1;
        m_tag[v]   = upc >> OFF;
        m_tgt[v]   = utgt;
        m_slot[v]  = (upc >> 2) % FW;
        m_type[v]  = uty;
        m_ctr[v]   = 2;
      end
    end
    if (fl) begin
      m_ras.delete();
    end else if (uv && ut) begin
      if (uty == 2) begin
        m_ras.push_back(upc + 4);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end else if (uty == 3 && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic drive(input bit fl, input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utgt, input logic [1:0] uty, input logic [31:0] lpc);
    bus.flush         = fl;
    bus.update_valid  = uv;
    bus.update_pc     = upc;
    bus.update_taken  = ut;
    bus.update_target = utgt;
    bus.update_type   = uty;
    bus.pc            = lpc;
  endtask

  // One cycle checked against the model; called just after a rising edge.
  task automatic cycle_model(input bit fl, input bit uv, input logic [31:0] upc, input bit ut,
                             input logic [31:0] utgt, input logic [1:0] uty, input logic [31:0] lpc);
    bit h, t;
    int unsigned nxt, cut;
    drive(fl, uv, upc, ut, utgt, uty, lpc);
    @(negedge clk);
    model_predict(lpc, h, t, nxt, cut);
    check("model_hit", 32'(bus.hit), 32'(h));
    check("model_taken", 32'(bus.taken), 32'(t));
    check("model_next", bus.next_fetch_pc, nxt);
    check("model_cut", 32'(bus.cut_pos), cut);
    check("model_pred_valid", 32'(bus.pred_valid), 32'(!fl));
    @(posedge clk);
    model_update(fl, uv, upc, ut, utgt, {30'b0, uty});
    #1;
  endtask

  // Lookup only, with explicit expectations.
  task automatic look(input string name, input logic [31:0] lpc, input bit eh, input logic [31:0] en);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, lpc);
    @(negedge clk);
    check({name, "_hit"}, 32'(bus.hit), 32'(eh));
    check({name, "_next"}, bus.next_fetch_pc, en);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] upc, lpc, utgt;
    logic [31:0] exp_next;
    int g;

    tbl[0]  = '{0, 0, 32'h0,    0, 32'h0,    2'd0, 32'h1000, 0, 0, 32'h1010, 0};
    tbl[1]  = '{0, 1, 32'h1004, 1, 32'h2000, 2'd0, 32'h1008, 0, 0, 32'h1010, 0};
    tbl[2]  = '{0, 0, 32'h0,    0, 32'h0,    2'd0, 32'h1008, 1, 1, 32'h2000, 2};
    tbl[3]  = '{0, 1, 32'h1004, 0, 32'h0,    2'd0, 32'h1000, 1, 1, 32'h2000, 2};
    tbl[4]  = '{0, 1, 32'h1004, 0, 32'h0,    2'd0, 32'h1000, 1, 0, 32'h1010, 0};
    tbl[5]  = '{0, 1, 32'h1004, 1, 32'h2000, 2'd0, 32'h1000, 1, 0, 32'h1010, 0};
    tbl[6]  = '{0, 1, 32'h1004, 1, 32'h2000, 2'd0, 32'h1000, 1, 0, 32'h1010, 0};
    tbl[7]  = '{0, 0, 32'h0,    0, 32'h0,    2'd0, 32'h1000, 1, 1, 32'h2000, 2};
    tbl[8]  = '{0, 1, 32'h4000, 1, 32'h9999, 2'd3, 32'h4000, 0, 0, 32'h4010, 0};
    tbl[9]  = '{0, 1, 32'h3008, 1, 32'h5000, 2'd2, 32'h4000, 1, 1, 32'h9999, 1};
    tbl[10] = '{0, 0, 32'h0,    0, 32'h0,    2'd0, 32'h4000, 1, 1, 32'h300C, 1};
    tbl[11] = '{1, 1, 32'h3008, 1, 32'h5000, 2'd2, 32'h4000, 1, 1, 32'h300C, 1};
    tbl[12] = '{0, 0, 32'h0,    0, 32'h0,    2'd0, 32'h4000, 1, 1, 32'h9999, 1};

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h1000);
    model_reset();
    #1;
    check("reset_hit", 32'(bus.hit), 32'h0);
    check("reset_next", bus.next_fetch_pc, 32'h1010);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors: training, same-cycle visibility, RAS and flush.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].fl, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, tbl[i].uty, tbl[i].lpc);
      @(negedge clk);
      check($sformatf("vec%0d_hit", i), 32'(bus.hit), 32'(tbl[i].eh));
      check($sformatf("vec%0d_taken", i), 32'(bus.taken), 32'(tbl[i].et));
      check($sformatf("vec%0d_next", i), bus.next_fetch_pc, tbl[i].en);
      check($sformatf("vec%0d_cut", i), 32'(bus.cut_pos), tbl[i].ec);
      check($sformatf("vec%0d_pred_valid", i), 32'(bus.pred_valid), 32'(!tbl[i].fl));
      @(posedge clk);
      model_update(tbl[i].fl, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, {30'b0, tbl[i].uty});
      #1;
    end

    // Replacement: fill, then two allocations evict entries 0 and 1 in order.
    do_reset();
    for (int i = 0; i < ENTRIES; i++)
      cycle_model(1'b0, 1'b1, 32'h0001_0000 + 32'(i * 16), 1'b1, 32'h8000 + 32'(i * 16), 2'd0, 32'h0);
    cycle_model(1'b0, 1'b1, 32'h0002_0000, 1'b1, 32'hA000, 2'd0, 32'h0);
    cycle_model(1'b0, 1'b1, 32'h0002_0010, 1'b1, 32'hA010, 2'd0, 32'h0);
    look("evict0", 32'h0001_0000, 1'b0, 32'h0001_0010);
    look("evict1", 32'h0001_0010, 1'b0, 32'h0001_0020);
    look("kept2", 32'h0001_0020, 1'b1, 32'h8020);
    look("new0", 32'h0002_0000, 1'b1, 32'hA000);
    look("new1", 32'h0002_0010, 1'b1, 32'hA010);

    // RAS overflow: RAS_DEPTH+1 calls, then RAS_DEPTH+1 returns.
    do_reset();
    cycle_model(1'b0, 1'b1, 32'h4000, 1'b1, 32'h9999, 2'd3, 32'h0);
    for (int i = 0; i <= RAS_DEPTH; i++)
      cycle_model(1'b0, 1'b1, 32'h3000 + 32'(4 * i), 1'b1, 32'h5000, 2'd2, 32'h0);
    for (int i = 0; i <= RAS_DEPTH; i++) begin
      exp_next = (i < RAS_DEPTH) ? 32'h3000 + 32'(4 * (RAS_DEPTH - i)) + 32'd4 : 32'h9999;
      drive(1'b0, 1'b1, 32'h4000, 1'b1, 32'h9999, 2'd3, 32'h4000);
      @(negedge clk);
      check($sformatf("ras_ret%0d_next", i), bus.next_fetch_pc, exp_next);
      @(posedge clk);
      model_update(1'b0, 1'b1, 32'h4000, 1'b1, 32'h9999, 3);
      #1;
    end

    // Randomized traffic against the model, including a group at the wrap point.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      g    = $urandom_range(24, 0);
      upc  = ((g == 24) ? 32'hFFFF_FFF0 : 32'h0001_0000 + 32'(g * 16)) + 32'($urandom_range(FW - 1, 0) * 4);
      g    = $urandom_range(24, 0);
      lpc  = ((g == 24) ? 32'hFFFF_FFF0 : 32'h0001_0000 + 32'(g * 16)) + 32'($urandom_range(FW - 1, 0) * 4);
      utgt = $urandom;
      cycle_model(($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0), upc,
                  1'($urandom_range(1, 0)), utgt, 2'($urandom_range(3, 0)), lpc);
    end

    // Asynchronous reset between edges while a trained group is looked up.
    do_reset();
    cycle_model(1'b0, 1'b1, 32'h0000_7004, 1'b1, 32'hBEE0, 2'd0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 32'h0000_7000);
    #1;
    check("pre_async_hit", 32'(bus.hit), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_hit", 32'(bus.hit), 32'h0);
    check("async_taken", 32'(bus.taken), 32'h0);
    check("async_cut", 32'(bus.cut_pos), 32'h0);
    check("async_next", bus.next_fetch_pc, 32'h0000_7010);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    look("post_rst_a", 32'h0000_7000, 1'b0, 32'h0000_7010);
    look("post_rst_b", 32'h0000_1000, 1'b0, 32'h0000_1010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
